// File: rtl/sobel_frame_streamer.sv
// Raster-order frame reader feeding the Sobel kernel: one pixel per cycle, optional inter-row gap.
// Latency mem_rd_o -> done_o is 2 cycles; no backpressure, the consumer must take every pixel.
module sobel_frame_streamer #(
  parameter int ROWS     = 480,
  parameter int COLS     = 640,
  parameter int LINE_GAP = 0,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        grayscale_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = $clog2(COLS);
  localparam int GAP_W = $clog2(LINE_GAP + 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, READ, GAP, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ADDR_W-1:0] addr;
  logic              rd_d1, last_d1;
  logic              row_end, frame_end;

  assign row_end    = (col == COL_LAST);
  assign frame_end  = row_end && (row == ROW_LAST);
  assign mem_addr_o = rst ? '0 : addr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd_o  = 1'b0;
    busy_o    = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = READ;
      READ: begin
        mem_rd_o = 1'b1;
        busy_o   = 1'b1;
        if (frame_end)                         state_nxt = FLUSH;
        else if (row_end && (LINE_GAP > 0))    state_nxt = GAP;
      end
      GAP: begin
        busy_o = 1'b1;
        if (gap_cnt == GAP_LAST) state_nxt = READ;
      end
      FLUSH: begin
        busy_o = 1'b1;
        // Leave only once the last pixel is actually on the bus.
        if (frame_done_o) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences the outputs immediately so no read is launched in the reset cycle.
    if (rst) begin
      mem_rd_o = 1'b0;
      busy_o   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row          <= '0;
      col          <= '0;
      gap_cnt      <= '0;
      addr         <= '0;
      rd_d1        <= 1'b0;
      last_d1      <= 1'b0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      grayscale_o  <= '0;
    end else begin
      rd_d1        <= mem_rd_o;
      last_d1      <= mem_rd_o && frame_end;
      done_o       <= rd_d1;
      frame_done_o <= last_d1;
      if (rd_d1) grayscale_o <= mem_data_i;

      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;

      if (state == READ) begin
        if (frame_end) begin
          row  <= '0;
          col  <= '0;
          addr <= '0;
        end else if (row_end) begin
          col  <= '0;
          row  <= row + 1'b1;
          addr <= addr + 1'b1;
        end else begin
          col  <= col + 1'b1;
          addr <= addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_streamer.sv
// Directed bench: two 3x4 streamers (gap 0 and gap 2) against word=address memories.
module tb_sobel_frame_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       rd_a, rd_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] mdat_a, mdat_b;
  logic [7:0] gray_a, gray_b;
  logic       done_a, done_b, busy_a, busy_b, fd_a, fd_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sobel_frame_streamer #(.ROWS(3), .COLS(4), .LINE_GAP(0), .ADDR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .mem_rd_o(rd_a), .mem_addr_o(addr_a),
    .mem_data_i(mdat_a), .grayscale_o(gray_a), .done_o(done_a), .busy_o(busy_a),
    .frame_done_o(fd_a));

  sobel_frame_streamer #(.ROWS(3), .COLS(4), .LINE_GAP(2), .ADDR_W(4)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .mem_rd_o(rd_b), .mem_addr_o(addr_b),
    .mem_data_i(mdat_b), .grayscale_o(gray_b), .done_o(done_b), .busy_o(busy_b),
    .frame_done_o(fd_b));

  // Synchronous frame memories whose word equals its address.
  always_ff @(posedge clk) begin
    mdat_a <= {4'h0, addr_a};
    mdat_b <= {4'h0, addr_b};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Gap-0 frame started at offset 0: reads 1..12, pixels 3..14, frame_done at 14.
  task automatic check_a(input string p, input int t);
    logic rd, dn;
    rd = (t >= 1 && t <= 12);
    dn = (t >= 3 && t <= 14);
    chk($sformatf("%s_rd@%0d", p, t),   32'(rd_a),   32'(rd));
    chk($sformatf("%s_busy@%0d", p, t), 32'(busy_a), 32'(t >= 1 && t <= 14));
    chk($sformatf("%s_done@%0d", p, t), 32'(done_a), 32'(dn));
    chk($sformatf("%s_fd@%0d", p, t),   32'(fd_a),   32'(t == 14));
    if (rd) chk($sformatf("%s_addr@%0d", p, t), 32'(addr_a), 32'(t - 1));
    if (dn) chk($sformatf("%s_gray@%0d", p, t), 32'(gray_a), 32'(t - 3));
  endtask

  // Gap-2 frame: each row slot is 4 reads then 2 idle cycles, no trailing gap.
  task automatic check_b(input int t);
    int  kr, kd;
    logic rd, dn;
    kr = t - 1;
    kd = t - 3;
    rd = (kr >= 0) && (kr / 6 < 3) && (kr % 6 < 4);
    dn = (kd >= 0) && (kd / 6 < 3) && (kd % 6 < 4);
    chk($sformatf("b_rd@%0d", t),   32'(rd_b),   32'(rd));
    chk($sformatf("b_busy@%0d", t), 32'(busy_b), 32'(t >= 1 && t <= 18));
    chk($sformatf("b_done@%0d", t), 32'(done_b), 32'(dn));
    chk($sformatf("b_fd@%0d", t),   32'(fd_b),   32'(t == 18));
    if (rd) chk($sformatf("b_addr@%0d", t), 32'(addr_b), 32'((kr / 6) * 4 + kr % 6));
    if (dn) chk($sformatf("b_gray@%0d", t), 32'(gray_b), 32'((kd / 6) * 4 + kd % 6));
  endtask

  initial begin
    int cnt_a, cnt_b, fd1, fd2, rd2, cnt1, cnt2;
    logic prev_rd;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd",   32'(rd_a),   32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_gray", 32'(gray_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_fd",   32'(fd_a),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy_b), 32'd0);

    // Single frames on both instances, started together.
    start_a = 1'b1; start_b = 1'b1;
    cnt_a = 0; cnt_b = 0;
    check_a("f1", 0);
    check_b(0);
    for (int t = 1; t <= 22; t++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      check_a("f1", t);
      check_b(t);
      cnt_a += int'(done_a);
      cnt_b += int'(done_b);
    end
    chk("a_pixels", 32'(cnt_a), 32'd12);
    chk("b_pixels", 32'(cnt_b), 32'd12);

    // Start held high: back-to-back frames, requests while busy ignored.
    start_a = 1'b1;
    fd1 = -1; fd2 = -1; rd2 = -1; cnt1 = 0; cnt2 = 0; prev_rd = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 29) start_a = 1'b0;
      if (done_a && t <= 14) cnt1++;
      if (done_a && t > 14) cnt2++;
      if (fd_a && fd1 < 0) fd1 = t;
      else if (fd_a && fd2 < 0) fd2 = t;
      if (rd_a && !prev_rd && t > 1 && rd2 < 0) rd2 = t;
      prev_rd = rd_a;
    end
    chk("hold_fd1",    32'(fd1),  32'd14);
    chk("hold_rd2",    32'(rd2),  32'd16);
    chk("hold_fd2",    32'(fd2),  32'd29);
    chk("hold_cnt1",   32'(cnt1), 32'd12);
    chk("hold_cnt2",   32'(cnt2), 32'd12);
    chk("hold_idle",   32'(busy_a), 32'd0);

    // Reset for one cycle during row 1 aborts the frame.
    start_a = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("abort_pre_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rd",   32'(rd_a),   32'd0);
    chk("abort_addr", 32'(addr_a), 32'd0);
    chk("abort_gray", 32'(gray_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_fd",   32'(fd_a),   32'd0);
    cnt_a = 0;
    for (int t = 8; t <= 20; t++) begin
      @(negedge clk);
      cnt_a += int'(done_a) + int'(fd_a) + int'(rd_a);
    end
    chk("abort_quiet", 32'(cnt_a), 32'd0);

    // Clean frame after the abort.
    start_a = 1'b1;
    cnt_a = 0;
    check_a("f2", 0);
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      start_a = 1'b0;
      check_a("f2", t);
      cnt_a += int'(done_a);
    end
    chk("f2_pixels", 32'(cnt_a), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
